// File: rtl/pipe_adder.sv
// Two-stage valid/ready adder pipeline: S1 holds operands, S2 holds the result.
// Define PIPE_ADDER_SUB_EN to add the in_sub port (1 = subtract, 0 = add).
// Ports: clk, rst_n (async, active-low), in_valid/in_ready/in_a/in_b [in_sub],
//        out_valid/out_ready/out (A_W+1 bits), txn_cnt (16-bit consumed count).
module pipe_adder #(
  parameter int A_W = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
`ifdef PIPE_ADDER_SUB_EN
  input  logic           in_sub,
`endif
  input  logic [A_W-1:0] in_a,
  input  logic [A_W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [A_W:0]   out,
  output logic [15:0]    txn_cnt
);

  logic           s1_vld_q, s1_vld_d;
  logic [A_W-1:0] s1_a_q, s1_a_d;
  logic [A_W-1:0] s1_b_q, s1_b_d;
`ifdef PIPE_ADDER_SUB_EN
  logic           s1_sub_q, s1_sub_d;
`endif
  logic           s2_vld_q, s2_vld_d;
  logic [A_W:0]   out_q, out_d;
  logic [15:0]    cnt_q, cnt_d;

  logic           s1_load;
  logic           s2_load;
  logic [A_W:0]   res;

  always_comb begin
    s2_load = !s2_vld_q || out_ready;
    s1_load = !s1_vld_q || s2_load;

`ifdef PIPE_ADDER_SUB_EN
    // Subtraction wraps modulo 2^(A_W+1).
    res = s1_sub_q ? ({1'b0, s1_a_q} - {1'b0, s1_b_q})
                   : ({1'b0, s1_a_q} + {1'b0, s1_b_q});
`else
    res = {1'b0, s1_a_q} + {1'b0, s1_b_q};
`endif

    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
`ifdef PIPE_ADDER_SUB_EN
    s1_sub_d = s1_sub_q;
`endif
    s2_vld_d = s2_vld_q;
    out_d    = out_q;

    if (s1_load) begin
      s1_vld_d = in_valid;
      if (in_valid) begin
        s1_a_d   = in_a;
        s1_b_d   = in_b;
`ifdef PIPE_ADDER_SUB_EN
        s1_sub_d = in_sub;
`endif
      end
    end

    // out keeps its last value when S2 drains without new data.
    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) out_d = res;
    end

    cnt_d = cnt_q + {15'd0, s2_vld_q && out_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
`ifdef PIPE_ADDER_SUB_EN
      s1_sub_q <= 1'b0;
`endif
      s2_vld_q <= 1'b0;
      out_q    <= '0;
      cnt_q    <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
`ifdef PIPE_ADDER_SUB_EN
      s1_sub_q <= s1_sub_d;
`endif
      s2_vld_q <= s2_vld_d;
      out_q    <= out_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = s1_load;
  assign out_valid = s2_vld_q;
  assign out       = out_q;
  assign txn_cnt   = cnt_q;

endmodule
